// File: rtl/vedic_mul_seq_ctrl.sv
// Iterative WIDTH x WIDTH unsigned multiplier sharing one vedic 4x4 core.
// Digit pairs are fed one per cycle and shift-accumulated into a 2*WIDTH sum.
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic w_t1, w_t2, w_t3, w_c1;

    assign w_t1 = a[1] & b[0];
    assign w_t2 = a[0] & b[1];
    assign w_t3 = a[1] & b[1];
    assign w_c1 = w_t1 & w_t2;

    assign p[0] = a[0] & b[0];
    assign p[1] = w_t1 ^ w_t2;
    assign p[2] = w_t3 ^ w_c1;
    assign p[3] = w_t3 & w_c1;
endmodule

module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] w_m0, w_m1, w_m2, w_m3;
    logic [5:0] w_mid;

    vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(w_m0));
    vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(w_m1));
    vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(w_m2));
    vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(w_m3));

    // Cross terms share weight 4, the high term weight 16.
    assign w_mid = {2'b00, w_m1} + {2'b00, w_m2};
    assign p     = {4'b0000, w_m0} + {w_mid, 2'b00} + {w_m3, 4'b0000};
endmodule

module vedic_mul_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int NDIG = WIDTH / 4;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int SW   = CW + 3;
    localparam int PW   = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_i;
    logic [CW-1:0]    r_j;
    logic             r_out_valid;
    logic             r_busy;

    logic [3:0]       w_a_dig;
    logic [3:0]       w_b_dig;
    logic [7:0]       w_pp;
    logic [SW-1:0]    w_shamt;
    logic [PW-1:0]    w_pp_sh;
    logic             w_accept;
    logic             w_last;

    assign w_a_dig = r_a[4*r_i +: 4];
    assign w_b_dig = r_b[4*r_j +: 4];

    vedic_4x4 u_core (.a(w_a_dig), .b(w_b_dig), .p(w_pp));

    assign w_shamt = (SW'(r_i) + SW'(r_j)) << 2;
    assign w_pp_sh = {{(PW-8){1'b0}}, w_pp} << w_shamt;
    assign w_last  = (r_i == LAST) && (r_j == LAST);

    assign in_ready  = rst_n && (r_state == IDLE);
    assign w_accept  = in_valid && in_ready && !abort;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_out_valid ? r_acc : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (abort && r_state != IDLE) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= r_acc + w_pp_sh;
                    if (r_j == LAST) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                    if (w_last) begin
                        r_i         <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
